// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 14-bit unsigned binary to four packed BCD digits.
// Define BCD_SATURATE_EN to clamp inputs above 9999 to 16'h9999 and flag overflow.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CONV  | one add-3/shift step per cycle, 14 steps in total
// DONE  | new result visible for one cycle, done pulses
module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [13:0] shift_q;
  logic [19:0] scratch_q;
  logic [3:0]  cnt_q;
  logic [15:0] bcd_q;
  logic [19:0] adj;
  logic [33:0] step;
  logic        last;

  // Digit 4 never exceeds 1 for a 14-bit input, so its adjust never fires in practice.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign step = {adj, shift_q} << 1;
  assign last = (cnt_q == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BCD_SATURATE_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= 14'd0;
      scratch_q <= 20'd0;
      cnt_q     <= 4'd0;
      bcd_q     <= 16'd0;
`ifdef BCD_SATURATE_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= 20'd0;
            cnt_q     <= 4'd14;
          end
        end
        CONV: begin
          scratch_q <= step[33:14];
          shift_q   <= step[13:0];
          cnt_q     <= cnt_q - 4'd1;
          if (last) begin
`ifdef BCD_SATURATE_EN
            if (step[33:30] != 4'd0) begin
              bcd_q <= 16'h9999;
              ovf_q <= 1'b1;
            end else begin
              bcd_q <= step[29:14];
              ovf_q <= 1'b0;
            end
`else
            bcd_q <= step[29:14];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;
`ifdef BCD_SATURATE_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: vector table, corner sequences and a partial sweep,
// with results checked through an expected-value queue as done pulses arrive.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t        tbl[14];
  logic [16:0] sb_q[$];
  logic [15:0] last_bcd;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int b);
    int   v;
    logic o;
    v = b;
    o = 1'b0;
`ifdef BCD_SATURATE_EN
    if (v > 9999) begin
      v = 9999;
      o = 1'b1;
    end
`else
    v = v % 10000;
`endif
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done: bcd=%h overflow=%b with no conversion pending", bcd, overflow);
      end else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        if ({bcd, overflow} !== e)
          begin
            failures++;
            $display("FAIL result: bcd=%h ovf=%b expected bcd=%h ovf=%b", bcd, overflow, e[16:1], e[0]);
          end
        for (int i = 0; i < 4; i++) begin
          if (bcd[i*4 +: 4] > 4'd9) begin
            failures++;
            $display("FAIL digit_range: bcd=%h digit %0d not decimal", bcd, i);
          end
        end
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; start is driven after edge N so the
  // done pulse appears at the 15th following negedge (the cycle after edge N+15).
  task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo,
                          input bit full);
    int  nbusy;
    int  lat;
    bit  seen;
    start = 1'b1;
    bin   = v;
    sb_q.push_back({eb, eo});
    nbusy = 0;
    lat   = 0;
    seen  = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        bin   = 14'($urandom);
      end
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done for bin=%0d", v);
      sb_q.delete();
    end else if (full) begin
      check("latency", lat, 15);
      check("busy_cycles", nbusy, 14);
    end
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{14'd0,     16'h0000, 1'b0};
    tbl[1]  = '{14'd1234,  16'h1234, 1'b0};
    tbl[2]  = '{14'd9999,  16'h9999, 1'b0};
`ifdef BCD_SATURATE_EN
    tbl[3]  = '{14'd12345, 16'h9999, 1'b1};
    tbl[4]  = '{14'd10000, 16'h9999, 1'b1};
    tbl[5]  = '{14'd16383, 16'h9999, 1'b1};
`else
    tbl[3]  = '{14'd12345, 16'h2345, 1'b0};
    tbl[4]  = '{14'd10000, 16'h0000, 1'b0};
    tbl[5]  = '{14'd16383, 16'h6383, 1'b0};
`endif
    tbl[6]  = '{14'd5,     16'h0005, 1'b0};
    tbl[7]  = '{14'd9,     16'h0009, 1'b0};
    tbl[8]  = '{14'd10,    16'h0010, 1'b0};
    tbl[9]  = '{14'd99,    16'h0099, 1'b0};
    tbl[10] = '{14'd100,   16'h0100, 1'b0};
    tbl[11] = '{14'd999,   16'h0999, 1'b0};
    tbl[12] = '{14'd1000,  16'h1000, 1'b0};
    tbl[13] = '{14'd8765,  16'h8765, 1'b0};

    reset = 1'b1;
    start = 1'b1;
    bin   = 14'd1234;
    repeat (3) @(negedge clk);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    start = 1'b0;

    foreach (tbl[i]) run_conv(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, 1'b1);
    last_bcd = tbl[13].bcd;

    // Restarts while busy and during DONE are ignored; bcd holds through CONV.
    begin
      int  k;
      bit  seen;
      start = 1'b1;
      bin   = 14'd42;
      sb_q.push_back({16'h0042, 1'b0});
      done_cnt = 0;
      seen = 1'b0;
      for (k = 1; k <= 40 && !seen; k++) begin
        @(negedge clk);
        start = (k == 5);
        bin   = (k == 1) ? 14'd42 : 14'd77;
        if (busy) check("bcd_hold", bcd, last_bcd);
        if (done) begin
          seen  = 1'b1;
          start = 1'b1;
          bin   = 14'd77;
        end
      end
      if (!seen) check("timeout_42", 0, 1);
      @(negedge clk);
      start = 1'b0;
      repeat (20) begin
        @(negedge clk);
        check("idle_after_done", busy, 0);
      end
      check("single_done", done_cnt, 1);
      check("bcd_42_held", bcd, 16'h0042);
    end

    // Reset during CONV cycle 7 aborts; restart on the first edge without reset.
    begin
      int nb;
      start = 1'b1;
      bin   = 14'd5678;
      nb    = 0;
      done_cnt = 0;
      for (int k = 1; k <= 20 && nb < 7; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (busy) nb++;
      end
      check("busy_before_abort", nb, 7);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_bcd", bcd, 16'h0000);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_ovf", overflow, 0);
      run_conv(14'd5678, 16'h5678, 1'b0, 1'b1);
      check("abort_one_done", done_cnt, 1);
      check("bcd_5678", bcd, 16'h5678);
    end

    for (int v = 0; v <= 600; v++) run_conv(14'(v), model(v) >> 1, model(v)[0], 1'b0);
    for (int v = 9980; v <= 10020; v++) run_conv(14'(v), model(v) >> 1, model(v)[0], 1'b0);
    for (int v = 16350; v <= 16383; v++) run_conv(14'(v), model(v) >> 1, model(v)[0], 1'b0);
    repeat (150) begin
      int v;
      v = int'($urandom_range(16383, 0));
      run_conv(14'(v), model(v) >> 1, model(v)[0], 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
